pu_mac_seq: RTL

Parametrised, time-multiplexed neuron processing unit that computes act(bias + Σ a[i]·w[i]) over N_INPUTS IEEE-754 single-precision operand pairs. It uses one FloatingMultiplication and one FloatingAddition instance, sequenced by an FSM, instead of a fully parallel multiplier and adder tree. Its new features are a configurable input count, an added bias term, a run-time activation mode, and valid/ready handshakes on both sides. It sits in a layer array as a drop-in neuron wherever area matters more than throughput.

---
 rtl/pu_mac_seq.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pu_mac_seq.sv
// Time-multiplexed neuron: out = act(bias + sum a[i]*w[i]) using one FP multiplier and one FP adder.
// Subnormal operands are treated as zero, and underflowing results flush to signed zero.

module FloatingMultiplication #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] p_o
);
    logic               sp, grd, stk, rup;
    logic [7:0]         ea, eb;
    logic [22:0]        ma, mb, mant, mant_r;
    logic [47:0]        mprod;
    logic [23:0]        rnd;
    logic signed [9:0]  exp_n, exp_r;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0]        res_d;
    logic [31:0]        pipe_q [LAT];

    always_comb begin
        ea     = a_i[30:23];
        eb     = b_i[30:23];
        ma     = a_i[22:0];
        mb     = b_i[22:0];
        sp     = a_i[31] ^ b_i[31];
        a_nan  = (ea == 8'hFF) && (ma != 23'd0);
        b_nan  = (eb == 8'hFF) && (mb != 23'd0);
        a_inf  = (ea == 8'hFF) && (ma == 23'd0);
        b_inf  = (eb == 8'hFF) && (mb == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        mprod  = {1'b1, ma} * {1'b1, mb};
        exp_n  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (mprod[47]) begin
            mant  = mprod[46:24];
            grd   = mprod[23];
            stk   = |mprod[22:0];
            exp_n = exp_n + 10'sd1;
        end else begin
            mant  = mprod[45:23];
            grd   = mprod[22];
            stk   = |mprod[21:0];
        end
        // round to nearest, ties to even
        rup    = grd & (stk | mant[0]);
        rnd    = {1'b0, mant} + {23'd0, rup};
        mant_r = rnd[22:0];
        exp_r  = rnd[23] ? exp_n + 10'sd1 : exp_n;

        res_d = 32'd0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res_d = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            res_d = {sp, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            res_d = {sp, 31'd0};
        else if (exp_r >= 10'sd255)
            res_d = {sp, 8'hFF, 23'd0};
        else if (exp_r <= 10'sd0)
            res_d = {sp, 31'd0};
        else
            res_d = {sp, exp_r[7:0], mant_r};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= 32'd0;
        end else begin
            pipe_q[0] <= res_d;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign p_o = pipe_q[LAT-1];
endmodule

module FloatingAddition #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] s_o
);
    logic               swap, eff_sub, grd, stk, rup;
    logic [31:0]        big, sml;
    logic [7:0]         ea, eb, diff;
    logic [50:0]        big_w, sml_w, sum_w;
    logic [48:0]        norm;
    logic [5:0]         lz;
    logic [22:0]        mant, mant_r;
    logic [23:0]        rnd;
    logic signed [9:0]  exp_n, exp_r;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0]        res_d;
    logic [31:0]        pipe_q [LAT];

    function automatic logic [5:0] lzc50(input logic [49:0] v);
        lzc50 = 6'd50;
        for (int i = 0; i < 50; i++) if (v[i]) lzc50 = 6'(49 - i);
    endfunction

    always_comb begin
        ea     = a_i[30:23];
        eb     = b_i[30:23];
        a_nan  = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
        a_inf  = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b_i[22:0] == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);

        // align the smaller magnitude onto the larger; beyond 26 places it cannot change the rounded result
        swap    = b_i[30:0] > a_i[30:0];
        big     = swap ? b_i : a_i;
        sml     = swap ? a_i : b_i;
        diff    = big[30:23] - sml[30:23];
        eff_sub = big[31] ^ sml[31];
        big_w   = {2'b01, big[22:0], 26'd0};
        sml_w   = {2'b01, sml[22:0], 26'd0} >> diff;
        sum_w   = eff_sub ? big_w - sml_w : big_w + sml_w;
        lz      = lzc50(sum_w[49:0]);
        norm    = 49'(sum_w[48:0] << lz);
        if (sum_w[50]) begin
            mant  = sum_w[49:27];
            grd   = sum_w[26];
            stk   = |sum_w[25:0];
            exp_n = $signed({2'b00, big[30:23]}) + 10'sd1;
        end else begin
            mant  = norm[48:26];
            grd   = norm[25];
            stk   = |norm[24:0];
            exp_n = $signed({2'b00, big[30:23]}) - $signed({4'b0000, lz});
        end
        rup    = grd & (stk | mant[0]);
        rnd    = {1'b0, mant} + {23'd0, rup};
        mant_r = rnd[22:0];
        exp_r  = rnd[23] ? exp_n + 10'sd1 : exp_n;

        res_d = 32'd0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31])))
            res_d = 32'h7FC0_0000;
        else if (a_inf)
            res_d = a_i;
        else if (b_inf)
            res_d = b_i;
        else if (a_zero && b_zero)
            res_d = {a_i[31] & b_i[31], 31'd0};
        else if (a_zero)
            res_d = b_i;
        else if (b_zero)
            res_d = a_i;
        else if (diff > 8'd26)
            res_d = big;
        else if (sum_w == 51'd0)
            res_d = 32'd0;
        else if (exp_r >= 10'sd255)
            res_d = {big[31], 8'hFF, 23'd0};
        else if (exp_r <= 10'sd0)
            res_d = {big[31], 31'd0};
        else
            res_d = {big[31], exp_r[7:0], mant_r};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= 32'd0;
        end else begin
            pipe_q[0] <= res_d;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign s_o = pipe_q[LAT-1];
endmodule

module pu_mac_seq #(
    parameter int N_INPUTS = 4,
    parameter int MUL_LAT  = 1,
    parameter int ADD_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [32*N_INPUTS-1:0]  a_in,
    input  logic [32*N_INPUTS-1:0]  w_in,
    input  logic [31:0]             bias,
    input  logic [1:0]              mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out,
    output logic                    busy
);
    localparam int IDX_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_ACT, S_DONE} state_t;

    state_t                 state_q;
    logic [32*N_INPUTS-1:0] a_q, w_q;
    logic [1:0]             mode_q;
    logic [31:0]            acc_q, prod_q, out_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   out_valid_q;
    logic [31:0]            mul_a, mul_b, mul_p, add_s, act_d;

    assign mul_a = a_q[32*idx_q +: 32];
    assign mul_b = w_q[32*idx_q +: 32];

    FloatingMultiplication #(.LAT(MUL_LAT)) u_mul (
        .clk (clk),
        .rst (rst),
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    FloatingAddition #(.LAT(ADD_LAT)) u_add (
        .clk (clk),
        .rst (rst),
        .a_i (acc_q),
        .b_i (prod_q),
        .s_o (add_s)
    );

    // mode 3 is reserved and falls through to identity
    always_comb begin
        act_d = acc_q;
        case (mode_q)
            2'd1:    act_d = acc_q[31] ? 32'd0 : acc_q;
            2'd2:    act_d = (!acc_q[31] && (acc_q[30:0] != 31'd0)) ? 32'h3F80_0000 : 32'd0;
            default: act_d = acc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            w_q         <= '0;
            mode_q      <= 2'd0;
            acc_q       <= 32'd0;
            prod_q      <= 32'd0;
            out_q       <= 32'd0;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a_in;
                        w_q     <= w_in;
                        mode_q  <= mode;
                        acc_q   <= bias;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (cnt_q == CNT_W'(MUL_LAT)) begin
                        prod_q  <= mul_p;
                        cnt_q   <= '0;
                        state_q <= S_ADD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ADD: begin
                    if (cnt_q == CNT_W'(ADD_LAT)) begin
                        acc_q <= add_s;
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_ACT;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= S_MUL;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ACT: begin
                    out_q       <= act_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;
endmodule
